riscv_single_block: RTL and testbench
=====================================

RISCV_SINGLE_BLOCK -- requirements
Module: riscv_single_block

Interface
REQ-001 Parameter IMEM_WORDS, default 256, SHALL set the instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 256, SHALL set the data memory depth in 32-bit words.
REQ-003 clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n, input, 1: reset SHALL be asynchronous and active-low.
REQ-005 matrixA_11, matrixA_12, matrixA_21, matrixA_22, inputs, 8 each: matrix A elements, unsigned.
REQ-006 matrixB_11, matrixB_12, matrixB_21, matrixB_22, inputs, 8 each: matrix B elements, unsigned.
REQ-007 ReLU, input, 1: output clamp enable.
REQ-008 matrixp00, matrixp01, matrixp10, matrixp11, outputs, 32 each: result registers P[row][col].
REQ-009 cycle_count, output, 32: clock cycles elapsed since reset release.
REQ-010 Memories SHALL be plain word arrays named instr_mem and data_mem.
- Benches preload them hierarchically with $readmemh.
- Index for both arrays: address[9:2].

Function
REQ-011 Core SHALL be a single-cycle RV32I subset executing one instruction per clock.
- Supported: LUI, AUIPC, JAL, JALR.
- Branches: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- Memory: LW, SW.
- OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL (low 32 bits).
REQ-012 Any other encoding SHALL execute as a NOP; PC advances by 4.
REQ-013 x0 SHALL read as zero; writes to x0 SHALL be discarded.
REQ-014 Instruction fetch and data loads SHALL be combinational reads; register-file writes and stores SHALL commit at the rising edge.
REQ-015 Data addresses 0x000-0x3FF SHALL map to data_mem. Only word accesses are supported; address bits [1:0] SHALL be ignored.
REQ-016 Read-only MMIO (loads zero-extended):
- 0x400 A11, 0x404 A12, 0x408 A21, 0x40C A22
- 0x410 B11, 0x414 B12, 0x418 B21, 0x41C B22
- 0x420 ReLU
REQ-017 Write-only MMIO: SW to 0x440/0x444/0x448/0x44C SHALL load the p00/p01/p10/p11 registers.
REQ-018 Loads from unmapped addresses SHALL return 0; stores to unmapped addresses SHALL be ignored.
REQ-019 PC SHALL wrap modulo IMEM_WORDS*4. Branch and jump targets SHALL have bit 0 cleared.
REQ-020 cycle_count SHALL increment by 1 every rising edge while rst_n=1 and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-021 rst_n=0 SHALL immediately set PC, all registers x1-x31, the four result registers and cycle_count to 0.
REQ-022 Reset SHALL NOT alter instr_mem or data_mem contents.
REQ-023 Reset asserted mid-program SHALL restart execution at address 0 on the first edge after release.

Configuration
REQ-024 With RISCV_SINGLE_RELU_EN defined:
- Each matrixpXY output SHALL show 0 when ReLU=1 and the register's bit 31 is 1.
- Otherwise the output SHALL show the register value.
- The clamp is combinational.
REQ-025 With RISCV_SINGLE_RELU_EN undefined, outputs SHALL show the registers unmodified and ReLU SHALL be readable only via MMIO.

Structure
REQ-026 A shared package SHALL hold the following, and the core SHALL use only these constants:
- opcode, funct3 and funct7 constants
- the MMIO address constants
- the ALU-operation enum
REQ-027 The ALU SHALL be one sub-module, riscv_single_alu (combinational, operands a/b plus op, 32-bit result). Decode, register file, memories and MMIO SHALL stay in the top.

Verification
REQ-028 Program "addi x1,x0,-5; sw x1,0x440(x0); jal x0,0" with ReLU=0: matrixp00=0xFFFFFFFB; with ReLU=1 (macro defined): matrixp00=0.
REQ-029 Matrix-multiply loop program with A=B=[[1,2],[3,4]]: p00=7, p01=10, p10=15, p11=22.
- Further runs with A=[[11,12],[13,14]], B=[[21,22],[23,24]]: p00=507, p01=530, p10=595, p11=622.
- Inputs change every 200 ns.
REQ-030 Release reset, count 10 rising edges: cycle_count=10. Reassert rst_n: cycle_count, PC and all matrixpXY immediately read 0.
REQ-031 Program "addi x0,x0,5; add x2,x0,x0; sw x2,0x444(x0)" run with matrixp01 preloaded to 0x1234: matrixp01=0, showing x0 is never written.
REQ-032 Branch coverage: "addi x1,x0,3; addi x1,x1,-1; bne x1,x0,-4; sw x1,0x448(x0)" SHALL leave matrixp10=0 after exactly 8 cycles. An unsupported opcode inserted before it SHALL change nothing except adding 1 cycle.

Source files
------------

// File: rtl/riscv_single_pkg.sv
// riscv_single_pkg: opcode/funct constants, MMIO map and ALU op enum shared by riscv_single_block.
package riscv_single_pkg;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LW   = 3'd2;
  localparam logic [2:0] F3_SW   = 3'd2;
  localparam logic [2:0] F3_JALR = 3'd0;
  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;
  localparam logic [31:0] DMEM_LIMIT = 32'h400;
  localparam logic [31:0] MMIO_A11  = 32'h400;
  localparam logic [31:0] MMIO_A12  = 32'h404;
  localparam logic [31:0] MMIO_A21  = 32'h408;
  localparam logic [31:0] MMIO_A22  = 32'h40c;
  localparam logic [31:0] MMIO_B11  = 32'h410;
  localparam logic [31:0] MMIO_B12  = 32'h414;
  localparam logic [31:0] MMIO_B21  = 32'h418;
  localparam logic [31:0] MMIO_B22  = 32'h41c;
  localparam logic [31:0] MMIO_RELU = 32'h420;
  localparam logic [31:0] MMIO_P00  = 32'h440;
  localparam logic [31:0] MMIO_P01  = 32'h444;
  localparam logic [31:0] MMIO_P10  = 32'h448;
  localparam logic [31:0] MMIO_P11  = 32'h44c;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
  } alu_op_e;
  // alt selects SUB/SRA over ADD/SRL
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/riscv_single_alu.sv
// riscv_single_alu: combinational RV32I ALU including low-word MUL.
module riscv_single_alu
  import riscv_single_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] y
);
  always_comb begin
    case (alu_op_e'(op))
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'd0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_MUL:  y = a * b;
      default:  y = a + b;
    endcase
  end
endmodule

// File: rtl/riscv_single_block.sv
// riscv_single_block: single-cycle RV32I subset core with matrix MMIO inputs and result registers.
// Define RISCV_SINGLE_RELU_EN to clamp negative result outputs to zero while ReLU=1.
module riscv_single_block
  import riscv_single_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  matrixA_11,
  input  logic [7:0]  matrixA_12,
  input  logic [7:0]  matrixA_21,
  input  logic [7:0]  matrixA_22,
  input  logic [7:0]  matrixB_11,
  input  logic [7:0]  matrixB_12,
  input  logic [7:0]  matrixB_21,
  input  logic [7:0]  matrixB_22,
  input  logic        ReLU,
  output logic [31:0] matrixp00,
  output logic [31:0] matrixp01,
  output logic [31:0] matrixp10,
  output logic [31:0] matrixp11,
  output logic [31:0] cycle_count
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);
  localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);
  logic [31:0] instr_mem [IMEM_WORDS];
  logic [31:0] data_mem [DMEM_WORDS];
  logic [31:0] regs_q [32];
  logic [31:0] p_q [4];
  logic [31:0] p_d [4];
  logic [31:0] pc_q, pc_d, pc_nx, pc_seq, cycle_count_q, cycle_count_d;
  logic [31:0] instr, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, alu_b, alu_y, rf_wd, ld_data, d_addr;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        rf_we, st_en, dmem_hit, br_taken, eq, lt, ltu, shift_ok, op_ok;
  alu_op_e     alu_op;

  assign instr  = instr_mem[pc_q[IA+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'd0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rs1_v  = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_v  = (rs2 == 5'd0) ? '0 : regs_q[rs2];
  assign pc_seq = pc_q + 32'd4;
  assign eq     = rs1_v == rs2_v;
  assign lt     = $signed(rs1_v) < $signed(rs2_v);
  assign ltu    = rs1_v < rs2_v;
  assign br_taken = (f3 == F3_BEQ)  ? eq   : (f3 == F3_BNE)  ? !eq  :
                    (f3 == F3_BLT)  ? lt   : (f3 == F3_BGE)  ? !lt  :
                    (f3 == F3_BLTU) ? ltu  : (f3 == F3_BGEU) ? !ltu : 1'b0;
  assign shift_ok = (f3 == F3_SLL) ? (f7 == F7_BASE) :
                    (f3 == F3_SR)  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
  assign op_ok    = (f7 == F7_BASE) || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) ||
                    (f7 == F7_MULDIV && f3 == F3_ADD);
  assign d_addr   = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign dmem_hit = d_addr < DMEM_LIMIT;

  riscv_single_alu u_alu (.a(rs1_v), .b(alu_b), .op(alu_op), .y(alu_y));

  always_comb begin
    case (d_addr)
      MMIO_A11:  ld_data = {24'd0, matrixA_11};
      MMIO_A12:  ld_data = {24'd0, matrixA_12};
      MMIO_A21:  ld_data = {24'd0, matrixA_21};
      MMIO_A22:  ld_data = {24'd0, matrixA_22};
      MMIO_B11:  ld_data = {24'd0, matrixB_11};
      MMIO_B12:  ld_data = {24'd0, matrixB_12};
      MMIO_B21:  ld_data = {24'd0, matrixB_21};
      MMIO_B22:  ld_data = {24'd0, matrixB_22};
      MMIO_RELU: ld_data = {31'd0, ReLU};
      default:   ld_data = dmem_hit ? data_mem[d_addr[DA+1:2]] : '0;
    endcase
  end

  // Unrecognised encodings fall through with all enables low: a NOP
  always_comb begin
    pc_nx  = pc_seq;
    rf_we  = 1'b0;
    rf_wd  = alu_y;
    st_en  = 1'b0;
    alu_b  = rs2_v;
    alu_op = ALU_ADD;
    case (opcode)
      OP_LUI:    begin rf_we = 1'b1; rf_wd = imm_u; end
      OP_AUIPC:  begin rf_we = 1'b1; rf_wd = pc_q + imm_u; end
      OP_JAL:    begin rf_we = 1'b1; rf_wd = pc_seq; pc_nx = (pc_q + imm_j) & ~32'd1; end
      OP_JALR:   if (f3 == F3_JALR) begin rf_we = 1'b1; rf_wd = pc_seq; pc_nx = (rs1_v + imm_i) & ~32'd1; end
      OP_BRANCH: pc_nx = br_taken ? ((pc_q + imm_b) & ~32'd1) : pc_seq;
      OP_LOAD:   if (f3 == F3_LW) begin rf_we = 1'b1; rf_wd = ld_data; end
      OP_STORE:  st_en = f3 == F3_SW;
      OP_IMM:    begin rf_we = shift_ok; alu_b = imm_i; alu_op = f3_to_op(f3, f3 == F3_SR && f7 == F7_ALT); end
      OP_OP:     begin rf_we = op_ok; alu_op = (f7 == F7_MULDIV) ? ALU_MUL : f3_to_op(f3, f7 == F7_ALT); end
      default:   rf_we = 1'b0;
    endcase
  end

  always_comb begin
    p_d[0] = (st_en && d_addr == MMIO_P00) ? rs2_v : p_q[0];
    p_d[1] = (st_en && d_addr == MMIO_P01) ? rs2_v : p_q[1];
    p_d[2] = (st_en && d_addr == MMIO_P10) ? rs2_v : p_q[2];
    p_d[3] = (st_en && d_addr == MMIO_P11) ? rs2_v : p_q[3];
  end

  assign pc_d          = pc_nx & PC_MASK;
  assign cycle_count_d = cycle_count_q + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= '0;
      cycle_count_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      for (int i = 0; i < 4; i++) p_q[i] <= '0;
    end else begin
      pc_q          <= pc_d;
      cycle_count_q <= cycle_count_d;
      p_q           <= p_d;
      if (rf_we && rd != 5'd0) regs_q[rd] <= rf_wd;
    end
  end

  // Memory contents survive reset; stores are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && st_en && dmem_hit) data_mem[d_addr[DA+1:2]] <= rs2_v;
  end

  assign cycle_count = cycle_count_q;
`ifdef RISCV_SINGLE_RELU_EN
  assign matrixp00 = (ReLU && p_q[0][31]) ? '0 : p_q[0];
  assign matrixp01 = (ReLU && p_q[1][31]) ? '0 : p_q[1];
  assign matrixp10 = (ReLU && p_q[2][31]) ? '0 : p_q[2];
  assign matrixp11 = (ReLU && p_q[3][31]) ? '0 : p_q[3];
`else
  assign matrixp00 = p_q[0];
  assign matrixp01 = p_q[1];
  assign matrixp10 = p_q[2];
  assign matrixp11 = p_q[3];
`endif
endmodule

// File: tb/tb_riscv_single_block.sv
// tb_riscv_single_block: directed programs with hand-computed results for riscv_single_block.
module tb_riscv_single_block;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] a11 = 0, a12 = 0, a21 = 0, a22 = 0, b11 = 0, b12 = 0, b21 = 0, b22 = 0;
  logic relu = 1'b0;
  logic [31:0] p00, p01, p10, p11, cyc;
  int vecs = 0;
  int errs = 0;
  logic [31:0] prog [$];
`ifdef RISCV_SINGLE_RELU_EN
  localparam logic [31:0] CLAMP_EXP = 32'h0;
`else
  localparam logic [31:0] CLAMP_EXP = 32'hFFFFFFFB;
`endif

  always #2 clk = ~clk;

  riscv_single_block dut (
    .clk(clk), .rst_n(rst_n),
    .matrixA_11(a11), .matrixA_12(a12), .matrixA_21(a21), .matrixA_22(a22),
    .matrixB_11(b11), .matrixB_12(b12), .matrixB_21(b21), .matrixB_22(b22),
    .ReLU(relu),
    .matrixp00(p00), .matrixp01(p01), .matrixp10(p10), .matrixp11(p11),
    .cycle_count(cyc)
  );

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs1, int rs2, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] rr(int f7, int f3, int rd, int rs1, int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] lw(int rd, int imm);
    return enc_i(imm, 0, 2, rd, 7'h03);
  endfunction
  function automatic logic [31:0] sw(int rs2, int imm);
    return {imm[11:5], rs2[4:0], 5'd0, 3'd2, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] jal0(int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'h6F};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic boot();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) dut.instr_mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("por_cycle", cyc, 32'd0);
    chk("por_p00", p00, 32'd0);
    chk("por_pc", dut.pc_q, 32'd0);

    prog = {addi(1, 0, -5), sw(1, 'h440), jal0(0)};
    boot();
    step(2);
    chk("relu0_p00", p00, 32'hFFFFFFFB);
    relu = 1'b1;
    step(1);
    chk("relu1_p00", p00, CLAMP_EXP);
    relu = 1'b0;

    prog = {enc_u(1, 5, 7'h37), addi(5, 5, 'h234), sw(5, 'h444), addi(0, 0, 5),
            rr(0, 0, 2, 0, 0), sw(2, 'h444), jal0(0)};
    boot();
    step(3);
    chk("x0_pre_p01", p01, 32'h1234);
    step(3);
    chk("x0_p01", p01, 32'h0);

    prog = {addi(1, 0, -16), enc_i('h402, 1, 5, 2, 7'h13), sw(2, 'h440), enc_i(28, 1, 5, 3, 7'h13),
            rr(0, 3, 4, 3, 1), rr(0, 2, 5, 3, 1), rr('h20, 0, 6, 3, 1), rr(0, 4, 7, 6, 4),
            enc_i(3, 7, 1, 7, 7'h13), rr(0, 6, 7, 7, 4), enc_i('h3F, 7, 7, 7, 7'h13), sw(7, 'h444),
            enc_u(0, 8, 7'h17), enc_i(13, 8, 0, 9, 7'h67), sw(1, 'h448), rr(0, 0, 10, 9, 8),
            sw(10, 'h448), enc_b(8, 1, 3, 4), sw(1, 'h44C), enc_b(8, 1, 3, 7), sw(1, 'h44C),
            sw(4, 'h44C), jal0(0)};
    boot();
    step(3);
    chk("alu_srai", p00, 32'hFFFFFFFC);
    step(22);
    chk("alu_logic", p01, 32'h31);
    chk("alu_jalr", p10, 32'h68);
    chk("alu_branch", p11, 32'h1);

    prog = {addi(1, 0, 3), addi(1, 1, -1), enc_b(-4, 1, 0, 1), sw(1, 'h448), jal0(0)};
    boot();
    step(7);
    chk("br_pc7", dut.pc_q, 32'd12);
    step(1);
    chk("br_pc8", dut.pc_q, 32'd16);
    chk("br_cyc8", cyc, 32'd8);
    chk("br_p10", p10, 32'd0);
    chk("br_x1", dut.regs_q[1], 32'd0);

    prog = {32'hFFFFFFFF, addi(1, 0, 3), addi(1, 1, -1), enc_b(-4, 1, 0, 1), sw(1, 'h448), jal0(0)};
    boot();
    step(8);
    chk("nop_pc8", dut.pc_q, 32'd16);
    step(1);
    chk("nop_pc9", dut.pc_q, 32'd20);
    chk("nop_x1", dut.regs_q[1], 32'd0);

    prog = {addi(1, 0, 'h55), sw(1, 8), lw(2, 8), sw(2, 'h44C), lw(3, 'h420), sw(3, 'h440),
            enc_u('h12345, 6, 7'h37), sw(6, 'h448), sw(1, 'h600), lw(5, 'h600),
            rr(0, 0, 5, 5, 1), sw(5, 'h444), jal0(0)};
    relu = 1'b1;
    boot();
    step(10);
    chk("cyc10", cyc, 32'd10);
    chk("dmem_p11", p11, 32'h55);
    chk("mmio_relu_p00", p00, 32'h1);
    chk("lui_p10", p10, 32'h12345000);
    step(2);
    chk("unmapped_p01", p01, 32'h55);
    chk("dmem_word2", dut.data_mem[2], 32'h55);
    rst_n = 1'b0;
    #1;
    chk("rst_cyc", cyc, 32'd0);
    chk("rst_pc", dut.pc_q, 32'd0);
    chk("rst_p", p00 | p01 | p10 | p11, 32'd0);
    chk("rst_x1", dut.regs_q[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("restart_pc", dut.pc_q, 32'd4);
    chk("restart_cyc", cyc, 32'd1);
    chk("mem_kept", dut.data_mem[2], 32'h55);
    relu = 1'b0;

    prog = {lw(1, 'h400), lw(2, 'h404), lw(3, 'h408), lw(4, 'h40C),
            lw(5, 'h410), lw(6, 'h414), lw(7, 'h418), lw(8, 'h41C),
            rr(1, 0, 9, 1, 5), rr(1, 0, 10, 2, 7), rr(0, 0, 9, 9, 10), sw(9, 'h440),
            rr(1, 0, 9, 1, 6), rr(1, 0, 10, 2, 8), rr(0, 0, 9, 9, 10), sw(9, 'h444),
            rr(1, 0, 9, 3, 5), rr(1, 0, 10, 4, 7), rr(0, 0, 9, 9, 10), sw(9, 'h448),
            rr(1, 0, 9, 3, 6), rr(1, 0, 10, 4, 8), rr(0, 0, 9, 9, 10), sw(9, 'h44C),
            jal0(-96)};
    {a11, a12, a21, a22} = {8'd1, 8'd2, 8'd3, 8'd4};
    {b11, b12, b21, b22} = {8'd1, 8'd2, 8'd3, 8'd4};
    boot();
    #200;
    chk("mm1_p00", p00, 32'd7);
    chk("mm1_p01", p01, 32'd10);
    chk("mm1_p10", p10, 32'd15);
    chk("mm1_p11", p11, 32'd22);
    {a11, a12, a21, a22} = {8'd11, 8'd12, 8'd13, 8'd14};
    {b11, b12, b21, b22} = {8'd21, 8'd22, 8'd23, 8'd24};
    #200;
    chk("mm2_p00", p00, 32'd507);
    chk("mm2_p01", p01, 32'd530);
    chk("mm2_p10", p10, 32'd595);
    chk("mm2_p11", p11, 32'd622);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
